// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the EX stage.
//   Runs mult/multu/div/divu as fixed-latency operations, writes HI/LO on
//   completion, and handles mthi/mtlo as single-edge register writes.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   start, op        - EX-stage MD instruction valid and its opcode
//   srcA, srcB       - forwarded rs/rt operands
//   md_inD           - ID-stage instruction touches HI/LO
//   busy             - multi-cycle operation in progress
//   stall_md         - combinational stall request to the hazard unit
//   hi, lo           - architectural HI/LO registers
//   stateDbg         - current FSM state, for observation only
// Handshake: start is a single-cycle request sampled on the rising edge. It is
// accepted only while busy is low (IDLE); while busy is high start is dropped
// silently and the requester must rely on stall_md to hold the pipeline.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        md_inD,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  stateDbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t        state, stateNext;
  logic [CW-1:0] count;
  logic [31:0]   opA, opB;
  logic          opSigned;

  logic          isMul, isDiv, lastCycle;
  logic [63:0]   prodS, prodU;
  logic [31:0]   quotS, remS, quotU, remU;
  logic          divOvf, divByZero;

  assign isMul     = (op == OP_MULT) || (op == OP_MULTU);
  assign isDiv     = (op == OP_DIV)  || (op == OP_DIVU);
  assign lastCycle = (count == CW'(1));

  // Results are derived only from the latched operands, so srcA/srcB may
  // change freely once an operation has been accepted.
  assign prodS = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
  assign prodU = {32'b0, opA} * {32'b0, opB};
  assign quotS = $signed(opA) / $signed(opB);
  assign remS  = $signed(opA) % $signed(opB);
  assign quotU = opA / opB;
  assign remU  = opA % opB;
  // Most-negative / -1 overflows 32 bits; pin the wrapped result explicitly.
  assign divOvf    = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
  assign divByZero = (opB == 32'b0);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start && isMul)      stateNext = MUL;
        else if (start && isDiv) stateNext = DIV;
      end
      MUL, DIV: begin
        if (lastCycle) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      opA      <= '0;
      opB      <= '0;
      opSigned <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start && (isMul || isDiv)) begin
            count    <= isMul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            opA      <= srcA;
            opB      <= srcB;
            opSigned <= ~op[0];
          end else if (start && op == OP_MTHI) begin
            hi <= srcA;
          end else if (start && op == OP_MTLO) begin
            lo <= srcA;
          end
        end
        MUL: begin
          count <= count - CW'(1);
          if (lastCycle) begin
            {hi, lo} <= opSigned ? prodS : prodU;
          end
        end
        DIV: begin
          count <= count - CW'(1);
          // A zero divisor still occupies the full latency but leaves HI/LO alone.
          if (lastCycle && !divByZero) begin
            if (!opSigned) begin
              lo <= quotU;
              hi <= remU;
            end else if (divOvf) begin
              lo <= 32'h8000_0000;
              hi <= 32'b0;
            end else begin
              lo <= quotS;
              hi <= remS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign stall_md = md_inD & (busy | (start & (isMul | isDiv)));
  assign stateDbg = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        md_inD;
  logic        busy, stall_md;
  logic [31:0] hi, lo;
  logic [1:0]  stateDbg;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] mHi, mLo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[10];

  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .md_inD(md_inD), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo),
    .stateDbg(stateDbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cycOf(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return MULT_CYCLES;
    if (o == 3'd2 || o == 3'd3) return DIV_CYCLES;
    return 0;
  endfunction

  // Reference model: architectural effect of one accepted operation.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = longint'(sa * sb); mHi = p[63:32]; mLo = p[31:0]; end
      3'd1: begin p = ua * ub; mHi = p[63:32]; mLo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; mLo = q[31:0]; mHi = r[31:0]; end
      3'd3: if (b != 0) begin mLo = a / b; mHi = a % b; end
      3'd4: mHi = a;
      3'd5: mLo = a;
      default: ;
    endcase
  endtask

  // Issue one operation in an idle cycle and follow it to its first idle cycle.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic md, input logic interfere);
    int cyc;
    cyc    = cycOf(o);
    start  = 1'b1;
    op     = o;
    srcA   = a;
    srcB   = b;
    md_inD = md;
    #1;
    chk("stall_accept", {31'b0, stall_md}, {31'b0, md & (cyc != 0)});
    step();
    start = 1'b0;
    srcA  = $urandom;
    srcB  = $urandom;
    for (int i = 1; i <= cyc; i++) begin
      if (interfere && i == 2) begin
        start = 1'b1;
        op    = 3'd1;
        srcA  = $urandom;
        srcB  = $urandom;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("stall_run", {31'b0, stall_md}, {31'b0, md});
      step();
    end
    start = 1'b0;
    #1;
    chk("busy_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd4, 32'h11,        32'h0,         32'h11,        32'hFFFF_FFFD};
    vecs[4] = '{3'd5, 32'h22,        32'h0,         32'h11,        32'h22};
    vecs[5] = '{3'd3, 32'h1234,      32'h0,         32'h11,        32'h22};
    vecs[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[7] = '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    vecs[8] = '{3'd3, 32'h64,        32'h7,         32'h2,         32'hE};
    vecs[9] = '{3'd6, 32'hDEAD,      32'hBEEF,      32'h2,         32'hE};

    reset = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0; md_inD = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'b0, stall_md}, 32'd0);
    mHi = '0;
    mLo = '0;

    // Directed table, back to back with no dead cycles.
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, i[0], 1'b0);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
      mHi = vecs[i].expHi;
      mLo = vecs[i].expLo;
    end

    // Running mult with a start injected mid-run, then mthi in the first idle cycle.
    runOp(3'd0, 32'h3, 32'h5, 1'b1, 1'b1);
    model(3'd0, 32'h3, 32'h5);
    chk("interf_hi", hi, mHi);
    chk("interf_lo", lo, mLo);
    runOp(3'd4, 32'hABCD, 32'h0, 1'b1, 1'b0);
    model(3'd4, 32'hABCD, 32'h0);
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_lo", lo, mLo);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      runOp(o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model(o, a, b);
      chk($sformatf("rnd%0d_hi", i), hi, mHi);
      chk($sformatf("rnd%0d_lo", i), lo, mLo);
    end

    // Reset three cycles into a div abandons it.
    start = 1'b1; op = 3'd2; srcA = 32'h100; srcB = 32'h3; md_inD = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    md_inD = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_md}, 32'd0);
    for (int i = 0; i < DIV_CYCLES + 2; i++) step();
    chk("rst_late_hi", hi, 32'd0);
    chk("rst_late_lo", lo, 32'd0);
    chk("rst_late_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: EX-stage cycles busy is held after a mult/multu is accepted.
REQ-002 Parameter DIV_CYCLES, default 10: EX-stage cycles busy is held after a div/divu is accepted.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: EX-stage MD instruction valid this cycle.
REQ-006 Port op  input  3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; other codes are a no-op.
REQ-007 Port srcA  input  32: forwarded rs value.
REQ-008 Port srcB  input  32: forwarded rt value.
REQ-009 Port md_inD  input  1: the ID-stage instruction uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 Port busy  output  1: a multi-cycle operation is in progress.
REQ-011 Port stall_md  output  1: stall request to the hazard unit, combinational.
REQ-012 Port hi  output  32: architectural HI register.
REQ-013 Port lo  output  32: architectural LO register.

Function
REQ-014 FSM states: IDLE, MUL, DIV; encoding is free.
REQ-015 IDLE, start=1, op=mult/multu -> MUL, count<=MULT_CYCLES, srcA/srcB latched.
REQ-016 IDLE, start=1, op=div/divu -> DIV, count<=DIV_CYCLES, srcA/srcB latched.
REQ-017 IDLE, start=1, op=mthi -> hi<=srcA on the same edge; op=mtlo -> lo<=srcA on the same edge; state stays IDLE; busy never asserts.
REQ-018 In MUL or DIV, count decrements by 1 per edge; on the edge where count goes 1->0, hi/lo are written and state returns to IDLE.
REQ-019 busy = (state != IDLE); start on edge N makes busy high for exactly N+1..N+CYCLES cycles, and the new hi/lo are visible in the first cycle busy is low.
REQ-020 start while busy is ignored: no restart, and neither the latched operands nor hi/lo change.
REQ-021 Start accepted in the same cycle busy falls (the IDLE cycle) is legal; back-to-back operations carry no dead cycle beyond that.
REQ-022 mult: {hi,lo} = signed 32x32 -> 64 product. multu: the unsigned product.
REQ-023 div: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-024 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-025 div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0, with no exception.
REQ-026 Divisor 0 (div or divu): the operation still runs DIV_CYCLES, and hi/lo keep their prior values.
REQ-027 The result is computed from the latched operands only; srcA/srcB changing after acceptance has no effect.
REQ-028 stall_md = md_inD & (busy | (start & op is mult/multu/div/divu)).
REQ-029 stall_md is combinational from inputs and state, with no register delay.
REQ-030 hi and lo are written only per REQ-017/REQ-018; no other path modifies them.

Reset
REQ-031 reset=1 at an edge: state<=IDLE, count<=0, hi<=0, lo<=0, latched operands<=0.
REQ-032 Reset takes priority over start and over an in-flight completion.
REQ-033 Reset mid-operation abandons the operation; no partial hi/lo write occurs.
REQ-034 busy=0 in the cycle after reset, and stall_md then depends only on start/op/md_inD.

Verification
REQ-035 multu srcA=0xFFFFFFFF, srcB=0x2 at edge N -> busy high for cycles N+1..N+5; after edge N+5 hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 mult srcA=0xFFFFFFFD (-3), srcB=7 -> after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-037 div srcA=0xFFFFFFF9 (-7), srcB=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 Divisor-zero case: divu srcB=0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles; hi/lo remain 0x11/0x22.
REQ-039 Busy/stall case: md_inD=1 during a running mult -> stall_md=1 each busy cycle; a second start mid-run is ignored; mthi 0xABCD in the first idle cycle -> hi=0xABCD next cycle with busy=0.
REQ-040 Reset-mid-op case: reset asserted 3 cycles into a div -> next cycle busy=0, hi=0, lo=0, and no later write occurs.
